// File: rtl/credit_tx_pkg.sv
// Shared helpers for the credit-based sender and its counter.
package credit_tx_pkg;

  // Counter width able to hold every value from 0 up to and including depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_tx_credit_counter.sv
// Saturating up/down credit counter with load-to-full and an overflow pulse.
// Shared with the receiver-side credit generator.
module credit_counter
  import credit_tx_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CNT_WIDTH = cnt_width(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic                 inc_i,
  input  logic                 dec_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 overflow_o
);

  localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] One    = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Next count: load wins, simultaneous inc/dec cancel, both ends saturate.
  always_comb begin
    cnt_d      = cnt_q;
    overflow_o = 1'b0;
    if (load_i) begin
      cnt_d = MaxCnt;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == MaxCnt) begin
        overflow_o = 1'b1;
      end else begin
        cnt_d = cnt_q + One;
      end
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - One;
    end
  end

  // Count register, full after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= MaxCnt;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/credit_tx.sv
// Credit-based sender: gates upstream valid/ready traffic on available remote
// FIFO credits and registers each accepted beat onto the push link.
module credit_tx
  import credit_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ALM_LOW_TH = 1,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  parameter int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  dtype                 data_i,
  output logic                 push_o,
  output dtype                 data_o,
  input  logic                 credit_i,
  output logic [CNT_WIDTH-1:0] credits_o,
  output logic                 alm_low_o,
  output logic                 err_o
);

  localparam logic [CNT_WIDTH-1:0] AlmTh = CNT_WIDTH'(ALM_LOW_TH);

  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;
  logic                 overflow;
  logic                 push_q, push_d;
  dtype                 data_q, data_d;
  logic                 err_q, err_d;

  // Flush discards the incoming credit; the counter reloads to full instead.
  credit_counter #(
    .DEPTH    (DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) i_credit_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (flush_i),
    .inc_i     (credit_i && !flush_i),
    .dec_i     (accept),
    .cnt_o     (cnt),
    .overflow_o(overflow)
  );

  // Handshake: ready comes only from the counter, blanked during flush.
  always_comb begin
    ready_o = (cnt != '0) && !flush_i;
    accept  = valid_i && ready_o;
  end

  // Output register and sticky error next-state.
  always_comb begin
    push_d = accept;
    data_d = data_q;
    err_d  = err_q;
    if (accept) begin
      data_d = data_i;
    end
    if (flush_i) begin
      push_d = 1'b0;
      err_d  = 1'b0;
    end else if (overflow) begin
      err_d = 1'b1;
    end
  end

  // Link-side registers; a reset drops any pending push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      push_q <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      push_q <= push_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign push_o    = push_q;
  assign data_o    = data_q;
  assign err_o     = err_q;
  assign credits_o = cnt;
  assign alm_low_o = (cnt <= AlmTh);

`ifndef COMMON_CELLS_ASSERTS_OFF
  if (DEPTH == 0) begin : g_depth_chk
    $error("credit_tx: DEPTH must be at least 1");
  end
  if (ALM_LOW_TH > DEPTH) begin : g_alm_chk
    $error("credit_tx: ALM_LOW_TH must not exceed DEPTH");
  end

  a_valid_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> valid_i)
    else $error("credit_tx: valid_i dropped before acceptance");

  a_data_held : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_i && !ready_o) |=> $stable(data_i))
    else $error("credit_tx: data_i changed before acceptance");
`endif

endmodule

// File: tb/tb_credit_tx.sv
// Directed bench for credit_tx with DEPTH=4, ALM_LOW_TH=1, 8-bit payload.
module tb_credit_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          valid_i;
  logic          ready_o;
  logic [DW-1:0] data_i;
  logic          push_o;
  logic [DW-1:0] data_o;
  logic          credit_i;
  logic [CW-1:0] credits_o;
  logic          alm_low_o;
  logic          err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  credit_tx #(
    .DATA_WIDTH(DW),
    .DEPTH     (4),
    .ALM_LOW_TH(1)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .flush_i  (flush_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .push_o   (push_o),
    .data_o   (data_o),
    .credit_i (credit_i),
    .credits_o(credits_o),
    .alm_low_o(alm_low_o),
    .err_o    (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs sampled at the falling edge, then inputs driven for the next rise.
  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni   = 1'b0;
    flush_i  = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;
    credit_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    chk("rst_credits", 32'(credits_o), 32'd4);
    chk("rst_ready",   32'(ready_o),   32'd1);
    chk("rst_push",    32'(push_o),    32'd0);
    chk("rst_alm",     32'(alm_low_o), 32'd0);
    chk("rst_err",     32'(err_o),     32'd0);
    chk("rst_data",    32'(data_o),    32'd0);

    // Drain: A0..A3 go out, A4 stays pending.
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'hA0 + 8'(i);
      tick();
      chk("drain_push",    32'(push_o),    32'd1);
      chk("drain_data",    32'(data_o),    32'hA0 + 32'(i));
      chk("drain_credits", 32'(credits_o), 32'(3 - i));
      chk("drain_alm",     32'(alm_low_o), (3 - i) <= 1 ? 32'd1 : 32'd0);
    end
    chk("drain_ready0", 32'(ready_o), 32'd0);
    data_i = 8'hA4;
    tick();
    chk("held_push",    32'(push_o),    32'd0);
    chk("held_data",    32'(data_o),    32'hA3);
    chk("held_credits", 32'(credits_o), 32'd0);
    chk("held_ready",   32'(ready_o),   32'd0);

    // One returned credit releases A4.
    credit_i = 1'b1;
    tick();
    credit_i = 1'b0;
    chk("ret_credits", 32'(credits_o), 32'd1);
    chk("ret_ready",   32'(ready_o),   32'd1);
    chk("ret_push",    32'(push_o),    32'd0);
    tick();
    valid_i = 1'b0;
    chk("ret_push1",    32'(push_o),    32'd1);
    chk("ret_data",     32'(data_o),    32'hA4);
    chk("ret_credits0", 32'(credits_o), 32'd0);
    tick();
    chk("ret_push_off", 32'(push_o), 32'd0);
    chk("ret_data_hold", 32'(data_o), 32'hA4);

    // Steady state at 2 credits: accept and credit every cycle.
    credit_i = 1'b1;
    repeat (2) tick();
    chk("ss_start", 32'(credits_o), 32'd2);
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'hB0 + 8'(i);
      tick();
      chk("ss_push",    32'(push_o),    32'd1);
      chk("ss_data",    32'(data_o),    32'hB0 + 32'(i));
      chk("ss_credits", 32'(credits_o), 32'd2);
    end
    valid_i = 1'b0;
    tick();
    chk("ss_end_push",    32'(push_o),    32'd0);
    chk("ss_end_credits", 32'(credits_o), 32'd3);

    // Overflow: credit at full count saturates and sets the sticky error.
    tick();
    chk("ovf_full", 32'(credits_o), 32'd4);
    chk("ovf_err0", 32'(err_o),     32'd0);
    tick();
    credit_i = 1'b0;
    chk("ovf_credits", 32'(credits_o), 32'd4);
    chk("ovf_err",     32'(err_o),     32'd1);
    tick();
    chk("ovf_sticky", 32'(err_o), 32'd1);

    // Drain to 1, then accept with a simultaneous credit at cnt=1.
    valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_i = 8'hC0 + 8'(i);
      tick();
    end
    chk("c_credits", 32'(credits_o), 32'd1);
    chk("c_err",     32'(err_o),     32'd1);
    data_i   = 8'hC3;
    credit_i = 1'b1;
    tick();
    chk("c1_credits", 32'(credits_o), 32'd1);
    chk("c1_ready",   32'(ready_o),   32'd1);
    chk("c1_push",    32'(push_o),    32'd1);
    chk("c1_data",    32'(data_o),    32'hC3);

    // Flush with valid and credit high at cnt=1.
    data_i  = 8'hC4;
    flush_i = 1'b1;
    #1;
    chk("fl_ready", 32'(ready_o), 32'd0);
    tick();
    flush_i  = 1'b0;
    credit_i = 1'b0;
    chk("fl_credits", 32'(credits_o), 32'd4);
    chk("fl_push",    32'(push_o),    32'd0);
    chk("fl_err",     32'(err_o),     32'd0);
    chk("fl_data",    32'(data_o),    32'hC3);
    tick();
    valid_i = 1'b0;
    chk("pf_push",    32'(push_o),    32'd1);
    chk("pf_data",    32'(data_o),    32'hC4);
    chk("pf_credits", 32'(credits_o), 32'd3);

    // Reset mid-transfer drops the pending push.
    valid_i = 1'b1;
    data_i  = 8'hD0;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    chk("mr_push_pre", 32'(push_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mr_push",    32'(push_o),    32'd0);
    chk("mr_data",    32'(data_o),    32'd0);
    chk("mr_credits", 32'(credits_o), 32'd4);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
